// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   clks_per_bit() - bit period in clk cycles for a given clock and baud rate
//   half_bit()     - counter value that marks the middle of a bit period
//   rx_state_t     - receiver FSM states
//   FRAME_*        - 8N1 frame layout, shared with uart_tx
package uart_pkg;

  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD_RATE = 115200;

  localparam int FRAME_START_BITS = 1;
  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_STOP_BITS = 1;
  localparam int FRAME_BITS = FRAME_START_BITS + FRAME_DATA_BITS + FRAME_STOP_BITS;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

  localparam int CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD_RATE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, counts 0..CLKS_PER_BIT-1 and wraps.
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - holds the counter at 0 (phase realignment)
//   half_tick  - counter is at the half-bit point
//   full_tick  - counter is at its last value; next cycle it wraps to 0
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic half_tick,
  output logic full_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(half_bit(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_tick = (cnt_q == HALF);
  assign full_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-word valid/ready output buffer.
//   clk, rst         - clock, asynchronous active-high reset
//   rx_sig           - serial line, idle high, asynchronous to clk
//   data_to_host     - received word (stable while valid_to_host)
//   valid_to_host    - data_to_host holds an unconsumed word
//   ready_from_host  - host accepts the word when valid && ready
//   frame_err        - one-cycle pulse: stop bit sampled low
//   overrun          - one-cycle pulse: good word dropped, buffer was full
//   busy             - FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | checking the start bit at its middle
// DATA  | sampling data bits mid-bit, LSB first
// STOP  | sampling the stop bit, delivering or dropping the word
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data_to_host,
  output logic                  valid_to_host,
  input  logic                  ready_from_host,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic sync1_q, sync2_q, prev_q;
  logic rx_s, rx_fall;

  rx_state_t state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;
  logic [DATA_WIDTH:0] shift_cat;

  logic cnt_clr, half_tick, full_tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CPB)
  ) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  assign rx_s = sync2_q;
  assign rx_fall = prev_q & ~sync2_q;
  assign shift_cat = {rx_s, shift_q};

  always_comb begin
    state_d = state_q;
    bit_idx_d = bit_idx_q;
    shift_d = shift_q;
    data_d = data_q;
    // an accept empties the buffer unless a new word lands in the same cycle
    valid_d = valid_q & ~ready_from_host;
    frame_err_d = 1'b0;
    overrun_d = 1'b0;
    cnt_clr = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rx_fall) begin
          state_d = START;
        end
      end
      START: begin
        if (half_tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            // restart the count here so later full_ticks land mid-bit
            cnt_clr = 1'b1;
            bit_idx_d = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_d = shift_cat[DATA_WIDTH:1];
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rx_s) begin
            if (!valid_q || ready_from_host) begin
              data_d = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q <= 1'b1;
      state_q <= IDLE;
      bit_idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q <= rx_sig;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      state_q <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_to_host = data_q;
  assign valid_to_host = valid_q;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
  assign busy = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the downstream counterpart of uart_tx. It deserialises 8N1 frames from the serial line (LSB first) and presents each received word on a valid/ready handshake to the host logic.
- Bit timing uses the same CLK_FREQ/BAUD_RATE division as the transmitter, with mid-bit sampling and start-bit validation.
- A one-word output buffer decouples the line from the consumer. Overrun and framing errors are flagged.

Parameters:
- DATA_WIDTH, 8, data bits per frame
- BAUD_RATE, 115200, line bit rate in bit/s
- CLK_FREQ, 100_000_000, clk frequency in Hz; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (868 at defaults)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_sig  in  1  serial line; idle high; asynchronous to clk
- data_to_host  out  DATA_WIDTH  received word
- valid_to_host  out  1  data_to_host holds an unconsumed word
- ready_from_host  in  1  host accepts the word when valid_to_host && ready_from_host
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  one-cycle pulse: good frame lost because the buffer was full
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - On rst, all outputs go to 0, the FSM goes to IDLE, counters clear, and the synchroniser flops preset to 1.
  - rst mid-frame aborts the frame with no output pulses. After release, the block waits for a new falling edge.
- Input synchronisation: 2-FF synchroniser on rx_sig, plus one extra register for edge detection. All sampling uses the synchronised value.
- Bit counter: counts 0..CLKS_PER_BIT-1. The half-bit point is CLKS_PER_BIT/2 (integer division).
- IDLE: a synchronised falling edge moves to START with the counter cleared.
- START: at the half-bit point, sample the line.
  - Line high: false start, return to IDLE, no pulses.
  - Line low: clear counter, bit index = 0, go to DATA.
- DATA: sample when the counter reaches CLKS_PER_BIT-1, i.e. mid-bit.
  - Shift the sample into the shift register, LSB first.
  - After bit index DATA_WIDTH-1, go to STOP.
- STOP: sample at mid-bit.
  - Sample = 1, buffer empty, or buffer being emptied in the same cycle (valid && ready): load data_to_host. valid_to_host rises on the next edge. Go to IDLE.
  - Sample = 1, buffer full and not being consumed: overrun pulse, word discarded, buffer unchanged. Go to IDLE.
  - Sample = 0: frame_err pulse, word discarded. Go to BREAK.
- BREAK: wait until the synchronised line is 1, then go to IDLE. A held-low line produces exactly one frame_err.
- Returning to IDLE at mid-stop lets back-to-back frames be received with no gap.
- Handshake:
  - valid_to_host stays high and data_to_host stays stable until accepted.
  - The buffer clears on the accept cycle.
  - Simultaneous accept and load: the new word replaces the old one and valid stays high.
- Latency: valid_to_host rises 1 clk after the mid-stop sample. That is about 2 + 9.5×CLKS_PER_BIT clks after the start edge on rx_sig.
- busy is high in START/DATA/STOP/BREAK.

Decomposition:
- Shared package uart_pkg holds:
  - CLKS_PER_BIT and the half-bit function (computed from parameters)
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - a frame-format constant shared with uart_tx
- One natural sub-module: uart_baud_cnt. It is the bit-period counter with clear input and outputs half_tick/full_tick, reusable by uart_tx.
- The synchroniser stays inline.

Test Plan:
- Single frame: drive 0xA5 at 868 clk/bit with ready_from_host=1 -> one valid_to_host cycle with data_to_host=0xA5, no error pulses.
- Back-to-back 0x5A then 0xC3 with no idle gap, ready held 1 -> two valid handshakes in order 0x5A, 0xC3.
- Glitch: rx_sig low for 200 clks, then high -> busy returns 0, no valid, no frame_err.
- Framing error: frame 0x3C with stop bit 0, line held low 3 bit-times -> exactly one frame_err pulse, no valid; the next good frame 0x81 is received correctly.
- Overrun: ready_from_host=0, send 0x11 then 0x22 -> valid high with 0x11, one overrun pulse at the second stop; assert ready -> 0x11 accepted, valid drops.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF -> outputs 0 immediately; after release, frame 0x96 is received with correct data. Also loopback uart_tx→uart_rx with 0x00, 0xFF, 0xA5 matches.
